// File: rtl/tpu_cfg_pkg.sv
// Shared definitions for the TPU configuration register bank: address map,
// per-context field layout, reset image, commit FSM states and parity helper.
package tpu_cfg_pkg;

   localparam int CFG_ACT_W   = 3;
   localparam int CFG_SHIFT_W = 5;

   localparam logic [3:0] CFG_PAGE_GLOBAL = 4'hF;

   // Per-context register offsets
   localparam logic [3:0] REG_ACT_TYPE    = 4'h0;
   localparam logic [3:0] REG_CLEAR_ACC   = 4'h1;
   localparam logic [3:0] REG_NORM_EN     = 4'h2;
   localparam logic [3:0] REG_QUANT_EN    = 4'h3;
   localparam logic [3:0] REG_QUANT_SHIFT = 4'h4;

   // Global page register offsets
   localparam logic [3:0] REG_CTRL   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h1;

   typedef struct packed {
      logic [CFG_ACT_W-1:0]   act_type;
      logic                   clear_acc;
      logic                   norm_en;
      logic                   quant_en;
      logic [CFG_SHIFT_W-1:0] quant_shift;
   } cfg_ctx_t;

   // ReLU, accumulator clear, normalization and quantization on, no shift
   localparam cfg_ctx_t CFG_CTX_RESET = '{
      act_type:    3'd1,
      clear_acc:   1'b1,
      norm_en:     1'b1,
      quant_en:    1'b1,
      quant_shift: 5'd0
   };

   typedef enum logic [0:0] {
      CFG_IDLE    = 1'b0,
      CFG_PENDING = 1'b1
   } cfg_fsm_e;

   // Even parity: stored bit makes the total count of ones across fields+bit even
   function automatic logic cfg_parity(input cfg_ctx_t ctx);
      return ^ctx;
   endfunction

endpackage

// File: rtl/cfg_regs_bank_if.sv
// Host-side register bus of the configuration bank: a valid/ready write
// channel and a combinational read port sharing the same 8-bit address map.
interface cfg_regs_bank_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_addr,
      input  wr_ready, rd_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_addr,
      output wr_ready, rd_data
   );
endinterface

// File: rtl/cfg_regs_bank.sv
// Multi-context double-buffered TPU config register file; shadow set copied to active only while core idle.
// Optional macro CFG_REGS_PARITY_EN adds per-context even parity on the active set with a sticky error.
module cfg_regs_bank
   import tpu_cfg_pkg::*;
#(
   parameter int NUM_CTX = 4,
   parameter int ACT_W   = CFG_ACT_W,
   parameter int SHIFT_W = CFG_SHIFT_W
) (
   input  logic               clk,
   input  logic               reset,
   cfg_regs_bank_if.slave     bus,
   input  logic               core_busy,
   input  logic [3:0]         ctx_sel,
   output logic [ACT_W-1:0]   act_type,
   output logic               clear_acc,
   output logic               norm_en,
   output logic               quant_en,
   output logic [SHIFT_W-1:0] quant_shift,
   output logic               cfg_updated,
   output logic               commit_pend,
   output logic               parity_err
);

   cfg_ctx_t  shadow_r [NUM_CTX];
   cfg_ctx_t  active_r [NUM_CTX];
   cfg_fsm_e  state_r;
   logic      wr_ready_r;
   logic      commit_pend_r;
   logic      cfg_updated_r;
   logic      addr_err_r;
   logic      parity_err_r;

   logic        wr_fire_s;
   logic [3:0]  wr_page_s;
   logic [3:0]  wr_reg_s;
   logic [3:0]  rd_page_s;
   logic [3:0]  rd_reg_s;
   logic        ctx_we_s;
   logic        commit_req_s;
   logic        addr_err_set_s;
   logic [1:0]  status_w1c_s;
   logic        par_mismatch_s;
   cfg_ctx_t    sel_ctx_s;
   cfg_ctx_t    rd_ctx_s;
   logic [31:0] rd_data_s;

   assign wr_fire_s = bus.wr_valid && wr_ready_r;
   assign wr_page_s = bus.wr_addr[7:4];
   assign wr_reg_s  = bus.wr_addr[3:0];
   assign rd_page_s = bus.rd_addr[7:4];
   assign rd_reg_s  = bus.rd_addr[3:0];

   // Classify the accepted write: shadow update, commit request, W1C or address error
   always_comb begin
      ctx_we_s       = 1'b0;
      commit_req_s   = 1'b0;
      addr_err_set_s = 1'b0;
      status_w1c_s   = 2'b00;
      if (!wr_fire_s) begin
         ctx_we_s = 1'b0;
      end else if (wr_page_s < 4'(NUM_CTX)) begin
         if (wr_reg_s <= REG_QUANT_SHIFT) begin
            ctx_we_s = 1'b1;
         end else begin
            addr_err_set_s = 1'b1;
         end
      end else if (wr_page_s == CFG_PAGE_GLOBAL) begin
         case (wr_reg_s)
            REG_CTRL: begin
               if (|bus.wr_data[31:1]) begin
                  addr_err_set_s = 1'b1;
               end else begin
                  commit_req_s = bus.wr_data[0];
               end
            end
            REG_STATUS: begin
               if (|bus.wr_data[31:3]) begin
                  addr_err_set_s = 1'b1;
               end else begin
                  status_w1c_s = bus.wr_data[2:1];
               end
            end
            default: addr_err_set_s = 1'b1;
         endcase
      end else begin
         addr_err_set_s = 1'b1;
      end
   end

`ifdef CFG_REGS_PARITY_EN
   logic [NUM_CTX-1:0] active_par_r;

   // Continuous parity check across every active context
   always_comb begin
      par_mismatch_s = 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
         par_mismatch_s = par_mismatch_s | (cfg_parity(active_r[i]) ^ active_par_r[i]);
      end
   end
`else
   assign par_mismatch_s = 1'b0;
`endif

   // Commit FSM, shadow writes, active load and sticky status bits
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= CFG_IDLE;
         wr_ready_r    <= 1'b1;
         commit_pend_r <= 1'b0;
         cfg_updated_r <= 1'b0;
         addr_err_r    <= 1'b0;
         parity_err_r  <= 1'b0;
         for (int i = 0; i < NUM_CTX; i++) begin
            shadow_r[i] <= CFG_CTX_RESET;
            active_r[i] <= CFG_CTX_RESET;
`ifdef CFG_REGS_PARITY_EN
            active_par_r[i] <= cfg_parity(CFG_CTX_RESET);
`endif
         end
      end else begin
         cfg_updated_r <= 1'b0;

         for (int i = 0; i < NUM_CTX; i++) begin
            if (ctx_we_s && (wr_page_s == 4'(i))) begin
               case (wr_reg_s)
                  REG_ACT_TYPE:    shadow_r[i].act_type    <= bus.wr_data[CFG_ACT_W-1:0];
                  REG_CLEAR_ACC:   shadow_r[i].clear_acc   <= bus.wr_data[0];
                  REG_NORM_EN:     shadow_r[i].norm_en     <= bus.wr_data[0];
                  REG_QUANT_EN:    shadow_r[i].quant_en    <= bus.wr_data[0];
                  REG_QUANT_SHIFT: shadow_r[i].quant_shift <= bus.wr_data[CFG_SHIFT_W-1:0];
                  default:         shadow_r[i]             <= shadow_r[i];
               endcase
            end
         end

         case (state_r)
            CFG_IDLE: begin
               if (commit_req_s) begin
                  state_r       <= CFG_PENDING;
                  wr_ready_r    <= 1'b0;
                  commit_pend_r <= 1'b1;
               end
            end
            CFG_PENDING: begin
               // Hold off until the datapath is idle; no timeout by design
               if (!core_busy) begin
                  for (int i = 0; i < NUM_CTX; i++) begin
                     active_r[i] <= shadow_r[i];
`ifdef CFG_REGS_PARITY_EN
                     active_par_r[i] <= cfg_parity(shadow_r[i]);
`endif
                  end
                  state_r       <= CFG_IDLE;
                  wr_ready_r    <= 1'b1;
                  commit_pend_r <= 1'b0;
                  cfg_updated_r <= 1'b1;
               end
            end
            default: begin
               state_r       <= CFG_IDLE;
               wr_ready_r    <= 1'b1;
               commit_pend_r <= 1'b0;
            end
         endcase

         // A new error event outranks a same-cycle clear
         addr_err_r   <= addr_err_set_s | (addr_err_r & ~status_w1c_s[0]);
         parity_err_r <= par_mismatch_s | (parity_err_r & ~status_w1c_s[1]);
      end
   end

   // Pick the active context driving the datapath; out-of-range selects context 0
   always_comb begin
      sel_ctx_s = active_r[0];
      for (int i = 1; i < NUM_CTX; i++) begin
         if (ctx_sel == 4'(i)) begin
            sel_ctx_s = active_r[i];
         end else begin
            sel_ctx_s = sel_ctx_s;
         end
      end
   end

   // Readback of shadow contexts and global status; unmapped addresses return zero
   always_comb begin
      rd_data_s = 32'd0;
      rd_ctx_s  = shadow_r[0];
      for (int i = 1; i < NUM_CTX; i++) begin
         if (rd_page_s == 4'(i)) begin
            rd_ctx_s = shadow_r[i];
         end else begin
            rd_ctx_s = rd_ctx_s;
         end
      end
      if (rd_page_s < 4'(NUM_CTX)) begin
         case (rd_reg_s)
            REG_ACT_TYPE:    rd_data_s = 32'(rd_ctx_s.act_type);
            REG_CLEAR_ACC:   rd_data_s = 32'(rd_ctx_s.clear_acc);
            REG_NORM_EN:     rd_data_s = 32'(rd_ctx_s.norm_en);
            REG_QUANT_EN:    rd_data_s = 32'(rd_ctx_s.quant_en);
            REG_QUANT_SHIFT: rd_data_s = 32'(rd_ctx_s.quant_shift);
            default:         rd_data_s = 32'd0;
         endcase
      end else if (rd_page_s == CFG_PAGE_GLOBAL) begin
         case (rd_reg_s)
            REG_STATUS: rd_data_s = 32'({parity_err_r, addr_err_r, commit_pend_r});
            default:    rd_data_s = 32'd0;
         endcase
      end else begin
         rd_data_s = 32'd0;
      end
   end

   assign bus.wr_ready = wr_ready_r;
   assign bus.rd_data  = rd_data_s;

   assign act_type    = sel_ctx_s.act_type;
   assign clear_acc   = sel_ctx_s.clear_acc;
   assign norm_en     = sel_ctx_s.norm_en;
   assign quant_en    = sel_ctx_s.quant_en;
   assign quant_shift = sel_ctx_s.quant_shift;
   assign cfg_updated = cfg_updated_r;
   assign commit_pend = commit_pend_r;
   assign parity_err  = parity_err_r;

endmodule

// File: tb/tb_cfg_regs_bank.sv
// Directed self-checking bench for cfg_regs_bank: reset image, commit timing,
// busy deferral, address errors, reset during a pending commit and parity.
module tb_cfg_regs_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       core_busy;
   logic [3:0] ctx_sel;
   logic [2:0] act_type;
   logic       clear_acc;
   logic       norm_en;
   logic       quant_en;
   logic [4:0] quant_shift;
   logic       cfg_updated;
   logic       commit_pend;
   logic       parity_err;

   int tests_run    = 0;
   int tests_failed = 0;

   cfg_regs_bank_if bus ();

   cfg_regs_bank #(
      .NUM_CTX (4),
      .ACT_W   (3),
      .SHIFT_W (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .core_busy   (core_busy),
      .ctx_sel     (ctx_sel),
      .act_type    (act_type),
      .clear_acc   (clear_acc),
      .norm_en     (norm_en),
      .quant_en    (quant_en),
      .quant_shift (quant_shift),
      .cfg_updated (cfg_updated),
      .commit_pend (commit_pend),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = addr;
      bus.wr_data  = data;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      core_busy    = 1'b0;
      ctx_sel      = 4'd0;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = 8'h00;
      bus.wr_data  = 32'd0;
      bus.rd_addr  = 8'hF1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (act_type !== 3'd1) begin tests_failed++; $display("FAIL reset_act: got %0d want 1", act_type); end
      tests_run++; if ({clear_acc, norm_en, quant_en} !== 3'b111) begin tests_failed++; $display("FAIL reset_flags: got %b want 111", {clear_acc, norm_en, quant_en}); end
      tests_run++; if (quant_shift !== 5'd0) begin tests_failed++; $display("FAIL reset_shift: got %0d want 0", quant_shift); end
      tests_run++; if ({cfg_updated, commit_pend, parity_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctl: got %b want 000", {cfg_updated, commit_pend, parity_err}); end
      tests_run++; if (bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
      #1;
      tests_run++; if (bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_status: got %0h want 0", bus.rd_data); end
   endtask

   task automatic test_commit();
      wr(8'h10, 32'd5);
      wr(8'h14, 32'd7);
      ctx_sel = 4'd1;
      wr(8'hF0, 32'd1);
      bus.rd_addr = 8'h10;
      #1;
      tests_run++; if (bus.rd_data !== 32'd5) begin tests_failed++; $display("FAIL commit_rd_shadow: got %0h want 5", bus.rd_data); end
      bus.rd_addr = 8'h14;
      #1;
      tests_run++; if (bus.rd_data !== 32'd7) begin tests_failed++; $display("FAIL commit_rd_shift: got %0h want 7", bus.rd_data); end
      tests_run++; if (act_type !== 3'd1) begin tests_failed++; $display("FAIL commit_act_early: got %0d want 1", act_type); end
      tests_run++; if ({commit_pend, bus.wr_ready, cfg_updated} !== 3'b100) begin tests_failed++; $display("FAIL commit_pend_state: got %b want 100", {commit_pend, bus.wr_ready, cfg_updated}); end
      @(negedge clk);
      tests_run++; if (act_type !== 3'd5 || quant_shift !== 5'd7) begin tests_failed++; $display("FAIL commit_applied: got act %0d shift %0d want 5 7", act_type, quant_shift); end
      tests_run++; if ({cfg_updated, commit_pend, bus.wr_ready} !== 3'b101) begin tests_failed++; $display("FAIL commit_done_state: got %b want 101", {cfg_updated, commit_pend, bus.wr_ready}); end
      @(negedge clk);
      tests_run++; if (cfg_updated !== 1'b0) begin tests_failed++; $display("FAIL commit_pulse_width: got %b want 0", cfg_updated); end
      ctx_sel = 4'd0;
      #1;
      tests_run++; if (act_type !== 3'd1) begin tests_failed++; $display("FAIL commit_ctx0_untouched: got %0d want 1", act_type); end
   endtask

   task automatic test_busy_defer();
      int bad = 0;
      core_busy = 1'b1;
      ctx_sel   = 4'd2;
      wr(8'h20, 32'd6);
      wr(8'h23, 32'd0);
      wr(8'h24, 32'hFFFF_FFE3);
      wr(8'h01, 32'd0);
      bus.rd_addr = 8'h24;
      #1;
      tests_run++; if (bus.rd_data !== 32'd3) begin tests_failed++; $display("FAIL busy_trunc_rd: got %0h want 3", bus.rd_data); end
      wr(8'hF0, 32'd1);
      for (int i = 0; i < 20; i++) begin
         if ({commit_pend, bus.wr_ready, cfg_updated} !== 3'b100 || act_type !== 3'd1 || quant_en !== 1'b1) begin
            bad++;
         end
         @(negedge clk);
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL busy_hold: got %0d bad cycles want 0", bad); end
      core_busy = 1'b0;
      @(negedge clk);
      tests_run++; if (act_type !== 3'd6 || quant_en !== 1'b0 || quant_shift !== 5'd3) begin tests_failed++; $display("FAIL busy_applied: got act %0d qen %b shift %0d want 6 0 3", act_type, quant_en, quant_shift); end
      tests_run++; if ({cfg_updated, commit_pend, bus.wr_ready} !== 3'b101) begin tests_failed++; $display("FAIL busy_done_state: got %b want 101", {cfg_updated, commit_pend, bus.wr_ready}); end
      ctx_sel = 4'd9;
      #1;
      tests_run++; if (clear_acc !== 1'b0 || act_type !== 3'd1) begin tests_failed++; $display("FAIL ctx_sel_oor: got clr %b act %0d want 0 1", clear_acc, act_type); end
   endtask

   task automatic test_addr_err();
      wr(8'h40, 32'd5);
      bus.rd_addr = 8'hF1;
      #1;
      tests_run++; if (bus.rd_data !== 32'd2) begin tests_failed++; $display("FAIL err_page: got %0h want 2", bus.rd_data); end
      bus.rd_addr = 8'h40;
      #1;
      tests_run++; if (bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL err_page_rd: got %0h want 0", bus.rd_data); end
      wr(8'hF1, 32'd2);
      bus.rd_addr = 8'hF1;
      #1;
      tests_run++; if (bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL err_w1c: got %0h want 0", bus.rd_data); end
      wr(8'h07, 32'd1);
      #1;
      tests_run++; if (bus.rd_data !== 32'd2) begin tests_failed++; $display("FAIL err_reg: got %0h want 2", bus.rd_data); end
      bus.rd_addr = 8'h00;
      #1;
      tests_run++; if (bus.rd_data !== 32'd1) begin tests_failed++; $display("FAIL err_no_write: got %0h want 1", bus.rd_data); end
      wr(8'hF1, 32'd2);
      wr(8'hF0, 32'd3);
      bus.rd_addr = 8'hF1;
      #1;
      tests_run++; if (bus.rd_data !== 32'd2 || commit_pend !== 1'b0) begin tests_failed++; $display("FAIL err_ctrl_bits: got %0h pend %b want 2 0", bus.rd_data, commit_pend); end
      wr(8'hF1, 32'd2);
      wr(8'hF0, 32'd0);
      #1;
      tests_run++; if (bus.rd_data !== 32'd0 || commit_pend !== 1'b0) begin tests_failed++; $display("FAIL ctrl_noop: got %0h pend %b want 0 0", bus.rd_data, commit_pend); end
   endtask

   task automatic test_reset_pending();
      int pulses = 0;
      core_busy = 1'b1;
      wr(8'h30, 32'd6);
      wr(8'hF0, 32'd1);
      tests_run++; if (commit_pend !== 1'b1) begin tests_failed++; $display("FAIL rstp_pend: got %b want 1", commit_pend); end
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      core_busy = 1'b0;
      tests_run++; if ({commit_pend, bus.wr_ready} !== 2'b01) begin tests_failed++; $display("FAIL rstp_state: got %b want 01", {commit_pend, bus.wr_ready}); end
      bus.rd_addr = 8'h30;
      #1;
      tests_run++; if (bus.rd_data !== 32'd1) begin tests_failed++; $display("FAIL rstp_shadow: got %0h want 1", bus.rd_data); end
      ctx_sel = 4'd1;
      #1;
      tests_run++; if (act_type !== 3'd1 || quant_shift !== 5'd0) begin tests_failed++; $display("FAIL rstp_active: got act %0d shift %0d want 1 0", act_type, quant_shift); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (cfg_updated !== 1'b0) pulses++;
      end
      ctx_sel = 4'd3;
      #1;
      tests_run++; if (pulses !== 0 || act_type !== 3'd1) begin tests_failed++; $display("FAIL rstp_no_commit: got pulses %0d act %0d want 0 1", pulses, act_type); end
   endtask

   task automatic test_parity();
`ifdef CFG_REGS_PARITY_EN
      force dut.active_par_r[0] = 1'b1;
      @(negedge clk);
      bus.rd_addr = 8'hF1;
      #1;
      tests_run++; if (parity_err !== 1'b1 || bus.rd_data !== 32'd4) begin tests_failed++; $display("FAIL parity_detect: got err %b status %0h want 1 4", parity_err, bus.rd_data); end
      release dut.active_par_r[0];
      wr(8'hF0, 32'd1);
      @(negedge clk);
      tests_run++; if (parity_err !== 1'b1) begin tests_failed++; $display("FAIL parity_sticky: got %b want 1", parity_err); end
      wr(8'hF1, 32'd4);
      #1;
      tests_run++; if (parity_err !== 1'b0 || bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL parity_w1c: got err %b status %0h want 0 0", parity_err, bus.rd_data); end
`else
      int seen = 0;
      bus.rd_addr = 8'hF1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (parity_err !== 1'b0 || bus.rd_data[2] !== 1'b0) seen++;
      end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL parity_tied: got %0d nonzero samples want 0", seen); end
`endif
   endtask

   initial begin
      test_reset();
      test_commit();
      test_busy_defer();
      test_addr_err();
      test_reset_pending();
      test_parity();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
